// File: rtl/spi_status_tx.sv
// rtl/spi_status_tx.sv - SPI mode-0 status word transmitter with holding register
// Host-clocked serial output; SCK/CS are synchronized into clk before any edge is used.
module spi_status_tx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_cs,
    input  logic             cfg_sck,
    output logic             cfg_so,
    output logic             so_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             frame_done,
    output logic             frame_abort,
    output logic             underrun
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q;
    logic                   cs_prev_q, sck_prev_q;
    logic [SYNC_STAGES:0]   primed_q;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             under_q, under_d;

    logic cs_s, sck_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall;
    logic enter_shift, leave_shift, accept;

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_rise = ~sck_prev_q & sck_s;
    assign sck_fall = sck_prev_q & ~sck_s;

    // primed_q keeps WAIT_IDLE from trusting the reset value of the CS synchronizer,
    // so a CS held low across reset is never mistaken for an idle-high level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
            primed_q   <= '0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cfg_cs};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], cfg_sck};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
            primed_q   <= {primed_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: if (primed_q[SYNC_STAGES] && cs_s) state_d = IDLE;
            IDLE:      if (cs_fall) state_d = SHIFT;
            SHIFT:     if (cs_rise) state_d = IDLE;
            default:   state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        so_oe  = (state_q == SHIFT);
        cfg_so = (state_q == SHIFT) && shift_q[WIDTH-1] && (cnt_q != FULL_CNT);
    end

    assign enter_shift = (state_q == IDLE) && (state_d == SHIFT);
    assign leave_shift = (state_q == SHIFT) && (state_d == IDLE);
    assign accept      = tx_valid && !hold_full_q;
    assign tx_ready    = !hold_full_q;

    // An accept can only happen while the holding register is empty, so it never
    // races a load into the shift register: the frame takes zeros, the word waits.
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        under_d     = 1'b0;
        done_d      = 1'b0;
        abort_d     = 1'b0;

        if (enter_shift) begin
            shift_d     = hold_full_q ? hold_q : '0;
            cnt_d       = '0;
            under_d     = !hold_full_q;
            hold_full_d = 1'b0;
        end else if (state_q == SHIFT) begin
            if (sck_fall) begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
            end
            if (sck_rise && (cnt_q != FULL_CNT)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (leave_shift) begin
            done_d  = (cnt_q == FULL_CNT);
            abort_d = (cnt_q != FULL_CNT);
        end

        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            under_q     <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            under_q     <= under_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign underrun    = under_q;

endmodule
